// File: rtl/timer0_control_unit.sv
// Timer0 control unit: I/O register file, clock-select prescaler, T0 pin
// synchroniser/edge detector, sticky overflow/compare flags and masked IRQs.
module timer0_control_unit #(
    parameter logic [5:0] ADDR_TCNT0 = 6'h32,
    parameter logic [5:0] ADDR_TCCR0 = 6'h33,
    parameter logic [5:0] ADDR_OCR0  = 6'h3C,
    parameter logic [5:0] ADDR_TIMSK = 6'h39,
    parameter logic [5:0] ADDR_TIFR  = 6'h38
) (
    input  logic       sysClock,
    input  logic       reset,
    input  logic [5:0] io_addr,
    input  logic       io_wr,
    input  logic       io_rd,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    input  logic [7:0] tcnt_value,
    input  logic       ovf_event,
    input  logic       cmp_event,
    input  logic       t0_pin,
    output logic       count_tick,
    output logic       tcnt_load,
    output logic [7:0] tcnt_load_data,
    output logic [7:0] ocr_value,
    output logic       irq_ovf,
    output logic       irq_cmp,
    input  logic       irq_ack_ovf,
    input  logic       irq_ack_cmp
);

    logic [7:0] tccr0_q, tccr0_d;
    logic [7:0] ocr0_q, ocr0_d;
    logic [7:0] timsk_q, timsk_d;
    logic       tov0_q, tov0_d;
    logic       ocf0_q, ocf0_d;
    logic [9:0] presc_q, presc_d;
    logic [2:0] t0_sync_q, t0_sync_d;
    logic [7:0] rdata_q, rdata_d;
    logic       load_q, load_d;
    logic [7:0] load_data_q, load_data_d;

    logic       wr_tcnt0, wr_tccr0, wr_ocr0, wr_timsk, wr_tifr;
    logic [2:0] cs0;
    logic       presc_run, cs_change;
    logic       t0_rise, t0_fall;
    logic       tick_raw;
    logic       clr_tov0, clr_ocf0;

    assign wr_tcnt0 = io_wr && (io_addr == ADDR_TCNT0);
    assign wr_tccr0 = io_wr && (io_addr == ADDR_TCCR0);
    assign wr_ocr0  = io_wr && (io_addr == ADDR_OCR0);
    assign wr_timsk = io_wr && (io_addr == ADDR_TIMSK);
    assign wr_tifr  = io_wr && (io_addr == ADDR_TIFR);

    assign cs0       = tccr0_q[2:0];
    assign presc_run = (cs0 >= 3'b010) && (cs0 <= 3'b101);
    assign cs_change = wr_tccr0 && (io_wdata[2:0] != cs0);

    // t0_sync_q[1] is the synchronised pin, t0_sync_q[2] its previous value
    assign t0_rise = t0_sync_q[1] & ~t0_sync_q[2];
    assign t0_fall = ~t0_sync_q[1] & t0_sync_q[2];

    assign clr_tov0 = (wr_tifr && io_wdata[0]) || irq_ack_ovf;
    assign clr_ocf0 = (wr_tifr && io_wdata[1]) || irq_ack_cmp;

    always_comb begin
        tick_raw = 1'b0;
        case (cs0)
            3'b000:  tick_raw = 1'b0;
            3'b001:  tick_raw = 1'b1;
            3'b010:  tick_raw = &presc_q[2:0];
            3'b011:  tick_raw = &presc_q[5:0];
            3'b100:  tick_raw = &presc_q[7:0];
            3'b101:  tick_raw = &presc_q;
            3'b110:  tick_raw = t0_fall;
            3'b111:  tick_raw = t0_rise;
            default: tick_raw = 1'b0;
        endcase
    end

    always_comb begin
        tccr0_d     = tccr0_q;
        ocr0_d      = ocr0_q;
        timsk_d     = timsk_q;
        load_d      = wr_tcnt0;
        load_data_d = load_data_q;
        if (wr_tccr0) tccr0_d = io_wdata;
        if (wr_ocr0)  ocr0_d  = io_wdata;
        if (wr_timsk) timsk_d = io_wdata;
        if (wr_tcnt0) load_data_d = io_wdata;

        // a new clock select always restarts the division from zero
        if (!presc_run || cs_change) presc_d = '0;
        else                         presc_d = presc_q + 10'd1;

        t0_sync_d = {t0_sync_q[1:0], t0_pin};

        // event set wins over W1C / acknowledge in the same cycle
        tov0_d = ovf_event | (tov0_q & ~clr_tov0);
        ocf0_d = cmp_event | (ocf0_q & ~clr_ocf0);

        rdata_d = rdata_q;
        if (io_rd) begin
            case (io_addr)
                ADDR_TCNT0: rdata_d = tcnt_value;
                ADDR_TCCR0: rdata_d = tccr0_q;
                ADDR_OCR0:  rdata_d = ocr0_q;
                ADDR_TIMSK: rdata_d = timsk_q;
                ADDR_TIFR:  rdata_d = {6'b0, ocf0_q, tov0_q};
                default:    rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge sysClock) begin
        if (reset) begin
            tccr0_q     <= '0;
            ocr0_q      <= '0;
            timsk_q     <= '0;
            tov0_q      <= 1'b0;
            ocf0_q      <= 1'b0;
            presc_q     <= '0;
            t0_sync_q   <= '0;
            rdata_q     <= '0;
            load_q      <= 1'b0;
            load_data_q <= '0;
        end else begin
            tccr0_q     <= tccr0_d;
            ocr0_q      <= ocr0_d;
            timsk_q     <= timsk_d;
            tov0_q      <= tov0_d;
            ocf0_q      <= ocf0_d;
            presc_q     <= presc_d;
            t0_sync_q   <= t0_sync_d;
            rdata_q     <= rdata_d;
            load_q      <= load_d;
            load_data_q <= load_data_d;
        end
    end

    // a pending preload suppresses the tick so the datapath never sees both
    assign count_tick     = tick_raw & ~load_q;
    assign tcnt_load      = load_q;
    assign tcnt_load_data = load_data_q;
    assign ocr_value      = ocr0_q;
    assign io_rdata       = rdata_q;
    assign irq_ovf        = tov0_q & timsk_q[0];
    assign irq_cmp        = ocf0_q & timsk_q[1];

endmodule

// File: tb/tb_timer0_control_unit.sv
// Scoreboard bench for timer0_control_unit: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_timer0_control_unit;

    localparam logic [5:0] A_TCNT0 = 6'h32;
    localparam logic [5:0] A_TCCR0 = 6'h33;
    localparam logic [5:0] A_OCR0  = 6'h3C;
    localparam logic [5:0] A_TIMSK = 6'h39;
    localparam logic [5:0] A_TIFR  = 6'h38;

    localparam int S_RDATA = 0, S_IRQO = 1, S_IRQC = 2, S_LOAD = 3, S_LDATA = 4, S_OCR = 5;

    logic       sysClock = 1'b0;
    logic       reset;
    logic [5:0] io_addr;
    logic       io_wr, io_rd;
    logic [7:0] io_wdata, io_rdata;
    logic [7:0] tcnt_value;
    logic       ovf_event, cmp_event, t0_pin;
    logic       count_tick, tcnt_load;
    logic [7:0] tcnt_load_data, ocr_value;
    logic       irq_ovf, irq_cmp, irq_ack_ovf, irq_ack_cmp;

    timer0_control_unit dut (
        .sysClock(sysClock), .reset(reset), .io_addr(io_addr), .io_wr(io_wr),
        .io_rd(io_rd), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .tcnt_value(tcnt_value), .ovf_event(ovf_event), .cmp_event(cmp_event),
        .t0_pin(t0_pin), .count_tick(count_tick), .tcnt_load(tcnt_load),
        .tcnt_load_data(tcnt_load_data), .ocr_value(ocr_value),
        .irq_ovf(irq_ovf), .irq_cmp(irq_cmp),
        .irq_ack_ovf(irq_ack_ovf), .irq_ack_cmp(irq_ack_cmp)
    );

    always #5 sysClock = ~sysClock;

    typedef struct {
        int         cyc;
        string      name;
        int         sig;
        logic [7:0] exp;
    } chk_t;

    chk_t chk_q[$];
    int   tick_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done = 1'b0;

    always @(posedge sysClock) cyc <= cyc + 1;

    function automatic logic [7:0] sample(input int sig);
        case (sig)
            S_RDATA: return io_rdata;
            S_IRQO:  return {7'b0, irq_ovf};
            S_IRQC:  return {7'b0, irq_cmp};
            S_LOAD:  return {7'b0, tcnt_load};
            S_LDATA: return tcnt_load_data;
            S_OCR:   return ocr_value;
            default: return 8'hxx;
        endcase
    endfunction

    // monitor: every cycle, compare whatever was scheduled for it
    always @(negedge sysClock) begin
        logic [7:0] act;
        bit hit;
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc == cyc) begin
                act = sample(chk_q[i].sig);
                n_cmp++;
                if (act !== chk_q[i].exp) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d actual=%02h required=%02h",
                             chk_q[i].name, cyc, act, chk_q[i].exp);
                end
                chk_q.delete(i);
            end
        end
        hit = 1'b0;
        for (int i = tick_q.size() - 1; i >= 0; i--)
            if (tick_q[i] == cyc) begin
                hit = 1'b1;
                tick_q.delete(i);
            end
        if (hit || count_tick !== 1'b0) begin
            n_cmp++;
            if (count_tick !== hit) begin
                n_err++;
                $display("FAIL count_tick cyc=%0d actual=%b required=%b", cyc, count_tick, hit);
            end
        end
        if (done) begin
            foreach (chk_q[i]) begin
                n_err++;
                $display("FAIL %s never compared (cyc=%0d)", chk_q[i].name, chk_q[i].cyc);
            end
            foreach (tick_q[i]) begin
                n_err++;
                $display("FAIL count_tick expected at cyc=%0d not seen", tick_q[i]);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    task automatic expect_at(input int c, input string name, input int sig, input logic [7:0] exp);
        chk_q.push_back('{c, name, sig, exp});
    endtask

    task automatic next_cyc();
        @(posedge sysClock);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) next_cyc();
    endtask

    // drive a one-cycle write now; eff is the first cycle showing its effect
    task automatic wr(input logic [5:0] a, input logic [7:0] d, output int eff);
        io_addr = a; io_wdata = d; io_wr = 1'b1;
        eff = cyc + 1;
        next_cyc();
        io_wr = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string name);
        io_addr = a; io_rd = 1'b1;
        expect_at(cyc + 1, name, S_RDATA, exp);
        next_cyc();
        io_rd = 1'b0;
    endtask

    task automatic pulse(input logic ov, input logic cm, input logic ao, input logic ac, output int eff);
        ovf_event = ov; cmp_event = cm; irq_ack_ovf = ao; irq_ack_cmp = ac;
        eff = cyc + 1;
        next_cyc();
        ovf_event = 1'b0; cmp_event = 1'b0; irq_ack_ovf = 1'b0; irq_ack_cmp = 1'b0;
    endtask

    initial begin
        int e, e2, e3, l, p;
        reset = 1'b1; io_addr = '0; io_wr = 1'b0; io_rd = 1'b0; io_wdata = '0;
        tcnt_value = 8'h00; ovf_event = 1'b0; cmp_event = 1'b0; t0_pin = 1'b0;
        irq_ack_ovf = 1'b0; irq_ack_cmp = 1'b0;
        repeat (3) next_cyc();
        expect_at(cyc, "rst_irq_ovf", S_IRQO, 8'h00);
        expect_at(cyc, "rst_irq_cmp", S_IRQC, 8'h00);
        expect_at(cyc, "rst_load", S_LOAD, 8'h00);
        expect_at(cyc, "rst_ocr", S_OCR, 8'h00);
        expect_at(cyc, "rst_rdata", S_RDATA, 8'h00);
        next_cyc();
        reset = 1'b0;
        next_cyc();

        rd(A_TCNT0, 8'h00, "rst_rd_tcnt0");
        rd(A_TCCR0, 8'h00, "rst_rd_tccr0");
        rd(A_OCR0,  8'h00, "rst_rd_ocr0");
        rd(A_TIMSK, 8'h00, "rst_rd_timsk");
        rd(A_TIFR,  8'h00, "rst_rd_tifr");

        // /8, then /1024, then stopped
        wr(A_TCCR0, 8'h02, e);
        for (int k = 0; k < 4; k++) tick_q.push_back(e + 7 + 8 * k);
        wait_to(e + 31);
        wr(A_TCCR0, 8'h05, e2);
        tick_q.push_back(e2 + 1023);
        tick_q.push_back(e2 + 2047);
        wait_to(e2 + 2047);
        wr(A_TCCR0, 8'h00, e3);
        wait_to(e3 + 20);

        // TCNT0 preload in /1 mode
        wr(A_TCCR0, 8'h01, e);
        l = e + 5;
        for (int c = e; c <= l + 5; c++) if (c != l) tick_q.push_back(c);
        expect_at(l - 1, "load_before", S_LOAD, 8'h00);
        expect_at(l, "load_pulse", S_LOAD, 8'h01);
        expect_at(l, "load_data", S_LDATA, 8'hF0);
        expect_at(l + 1, "load_end", S_LOAD, 8'h00);
        wait_to(e + 4);
        wr(A_TCNT0, 8'hF0, e);
        wait_to(l + 5);
        wr(A_TCCR0, 8'h00, e);
        next_cyc();

        // flags and interrupts
        wr(A_TIMSK, 8'h03, e);
        pulse(1, 0, 0, 0, e);
        expect_at(e, "ovf_set_irq", S_IRQO, 8'h01);
        expect_at(e, "ovf_set_nocmp", S_IRQC, 8'h00);
        wr(A_TIFR, 8'h02, e);
        expect_at(e, "w1c_other_bit", S_IRQO, 8'h01);
        rd(A_TIFR, 8'h01, "tifr_after_w02");
        wr(A_TIFR, 8'h01, e);
        expect_at(e, "w1c_tov0", S_IRQO, 8'h00);
        rd(A_TIFR, 8'h00, "tifr_after_w01");
        pulse(0, 1, 0, 1, e);
        expect_at(e, "cmp_vs_ack", S_IRQC, 8'h01);
        rd(A_TIFR, 8'h02, "tifr_ocf0");
        pulse(0, 0, 0, 1, e);
        expect_at(e, "ack_cmp", S_IRQC, 8'h00);
        ovf_event = 1'b1;
        wr(A_TIFR, 8'h01, e);
        ovf_event = 1'b0;
        expect_at(e, "ovf_vs_w1c", S_IRQO, 8'h01);
        pulse(1, 0, 1, 0, e);
        expect_at(e, "ovf_vs_ack", S_IRQO, 8'h01);
        pulse(0, 0, 1, 0, e);
        expect_at(e, "ack_ovf", S_IRQO, 8'h00);

        wr(A_TIMSK, 8'h00, e);
        pulse(1, 1, 0, 0, e);
        expect_at(e, "masked_ovf", S_IRQO, 8'h00);
        expect_at(e, "masked_cmp", S_IRQC, 8'h00);
        rd(A_TIFR, 8'h03, "tifr_both");
        wr(A_TIMSK, 8'h01, e);
        expect_at(e, "unmask_ovf", S_IRQO, 8'h01);
        expect_at(e, "still_masked_cmp", S_IRQC, 8'h00);
        wr(A_TIFR, 8'hFF, e);
        rd(A_TIFR, 8'h00, "tifr_cleared");

        // register readback
        wr(A_OCR0, 8'hA5, e);
        expect_at(e, "ocr_value", S_OCR, 8'hA5);
        wr(6'h3A, 8'hFF, e);
        rd(A_OCR0, 8'hA5, "rd_ocr0");
        rd(A_TIMSK, 8'h01, "rd_timsk");
        wr(A_TCCR0, 8'hF8, e);
        rd(A_TCCR0, 8'hF8, "rd_tccr0_hi");
        tcnt_value = 8'h5A;
        rd(A_TCNT0, 8'h5A, "rd_tcnt0");
        rd(6'h00, 8'h00, "rd_unmapped");
        wait_to(cyc + 10);

        // external clock edges
        wr(A_TCCR0, 8'h07, e);
        wait_to(e + 5);
        t0_pin = 1'b1; p = cyc;
        tick_q.push_back(p + 2);
        wait_to(p + 10);
        t0_pin = 1'b0;
        wait_to(cyc + 10);
        wr(A_TCCR0, 8'h06, e);
        wait_to(e + 3);
        t0_pin = 1'b1;
        wait_to(cyc + 10);
        t0_pin = 1'b0; p = cyc;
        tick_q.push_back(p + 2);
        wait_to(p + 10);

        done = 1'b1;
        next_cyc();
    end

endmodule
